sha256_padder: RTL and testbench



---
 rtl/sha256_padder.sv | 107 ++++++++++
 tb/tb_sha256_padder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [7:0]   i_in_data,
    input  logic         i_in_last,
    output logic         o_blk_valid,
    input  logic         i_blk_ready,
    output logic [511:0] o_blk,
    output logic         o_blk_last
);

    typedef enum logic [1:0] {
        StFill,
        StPad,
        StLenb,
        StEmit
    } state_e;

    state_e             r_state;
    state_e             r_next;
    logic [6:0]         r_ptr;
    logic [LEN_W-1:0]   r_bytecnt;
    logic [511:0]       r_buf;
    logic               r_last;

    logic [63:0]        w_bitlen;
    logic [5:0]         w_idx;
    logic [8:0]         w_boff;
    logic               w_accept;

    assign w_bitlen = 64'(r_bytecnt) << 3;
    assign w_idx    = r_ptr[5:0];
    // Byte k lives at bit offset (63-k)*8.
    assign w_boff   = {~w_idx, 3'b000};
    assign w_accept = i_in_valid && (r_state == StFill);

    assign o_in_ready  = (r_state == StFill);
    assign o_blk_valid = (r_state == StEmit);
    assign o_blk       = r_buf;
    assign o_blk_last  = r_last;

    // Buffer bytes beyond ptr are always zero, so padding only writes marker and length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StFill;
            r_next    <= StFill;
            r_ptr     <= '0;
            r_bytecnt <= '0;
            r_buf     <= '0;
            r_last    <= 1'b0;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (w_accept) begin
                        r_buf[w_boff +: 8] <= i_in_data;
                        r_ptr              <= r_ptr + 7'd1;
                        r_bytecnt          <= r_bytecnt + LEN_W'(1);
                        if (w_idx == 6'd63) begin
                            r_state <= StEmit;
                            r_last  <= 1'b0;
                            r_next  <= i_in_last ? StPad : StFill;
                        end else if (i_in_last) begin
                            r_state <= StPad;
                        end
                    end
                end
                StPad: begin
                    r_buf[w_boff +: 8] <= 8'h80;
                    if (r_ptr <= 7'd55) begin
                        r_buf[63:0] <= w_bitlen;
                        r_last      <= 1'b1;
                        r_next      <= StFill;
                    end else begin
                        r_last <= 1'b0;
                        r_next <= StLenb;
                    end
                    r_state <= StEmit;
                end
                StLenb: begin
                    r_buf[63:0] <= w_bitlen;
                    r_last      <= 1'b1;
                    r_next      <= StFill;
                    r_state     <= StEmit;
                end
                StEmit: begin
                    if (i_blk_ready) begin
                        r_state <= r_next;
                        r_ptr   <= '0;
                        r_buf   <= '0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_bytecnt <= '0;
                        end
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder against a byte-queue padding model.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [7:0]   i_in_data;
    logic         i_in_last;
    logic         o_blk_valid;
    logic         i_blk_ready;
    logic [511:0] o_blk;
    logic         o_blk_last;

    sha256_padder #(.LEN_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_last   (i_in_last),
        .o_blk_valid (o_blk_valid),
        .i_blk_ready (i_blk_ready),
        .o_blk       (o_blk),
        .o_blk_last  (o_blk_last)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    byte unsigned m_bytes[$];
    logic [511:0] exp_blk[$];
    logic         exp_last[$];
    logic [511:0] cap_blk[$];
    logic         cap_last[$];
    int acc_cyc_first, acc_cyc_last, hs_cyc_last, valid_first, valid_cnt;

    // Pad message bytes with plain queue operations, then slice into 64-byte blocks.
    function automatic void build_expected();
        byte unsigned    p[$];
        longint unsigned bits;
        logic [511:0]    b;
        int              nblk;
        exp_blk.delete();
        exp_last.delete();
        p    = m_bytes;
        bits = longint'(m_bytes.size()) * 8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        for (int n = 0; n < nblk; n++) begin
            b = '0;
            for (int k = 0; k < 64; k++) b[511 - 8 * k -: 8] = p[n * 64 + k];
            exp_blk.push_back(b);
            exp_last.push_back(n == nblk - 1);
        end
    endfunction

    task automatic run_msg(input int gap_pct, input int rdy_pct, input string name);
        int idx    = 0;
        int budget = 0;
        build_expected();
        cap_blk.delete();
        cap_last.delete();
        valid_first   = -1;
        valid_cnt     = 0;
        acc_cyc_first = -1;
        while (!(idx == m_bytes.size() && cap_blk.size() >= exp_blk.size()) && budget < 5000) begin
            if (idx < m_bytes.size() && $urandom_range(0, 99) >= gap_pct) begin
                i_in_valid = 1'b1;
                i_in_data  = m_bytes[idx];
                i_in_last  = (idx == m_bytes.size() - 1);
            end else begin
                i_in_valid = 1'b0;
                i_in_data  = 8'($urandom);
                i_in_last  = 1'($urandom);
            end
            i_blk_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            cyc++;
            if (o_blk_valid) begin
                valid_cnt++;
                if (valid_first < 0) valid_first = cyc;
            end
            if (i_in_valid && o_in_ready) begin
                if (idx == 0) acc_cyc_first = cyc;
                acc_cyc_last = cyc;
                idx++;
            end
            if (o_blk_valid && i_blk_ready) begin
                cap_blk.push_back(o_blk);
                cap_last.push_back(o_blk_last);
                hs_cyc_last = cyc;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        i_in_valid = 1'b0;
        n_total++;
        if (budget >= 5000 || cap_blk.size() != exp_blk.size())
            $display("FAIL %s blkcount: got %0d want %0d (budget %0d)", name, cap_blk.size(),
                     exp_blk.size(), budget);
        else n_pass++;
        for (int i = 0; i < exp_blk.size(); i++) begin
            if (i < cap_blk.size()) begin
                n_total++;
                if (cap_blk[i] !== exp_blk[i] || cap_last[i] !== exp_last[i])
                    $display("FAIL %s blk%0d: got %h last %b want %h last %b", name, i,
                             cap_blk[i], cap_last[i], exp_blk[i], exp_last[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic drive_bytes(input bit with_last);
        int bound;
        for (int idx = 0; idx < m_bytes.size(); idx++) begin
            i_in_valid = 1'b1;
            i_in_data  = m_bytes[idx];
            i_in_last  = with_last && (idx == m_bytes.size() - 1);
            bound      = 0;
            @(negedge clk);
            while (!o_in_ready && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 20) begin
                n_total++;
                $display("FAIL drive timeout: in_ready %b want 1", o_in_ready);
            end
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic set_abc();
        m_bytes.delete();
        m_bytes.push_back(8'h61);
        m_bytes.push_back(8'h62);
        m_bytes.push_back(8'h63);
    endtask

    task automatic check_abc_block(input string name);
        logic [511:0] b;
        n_total++;
        if (cap_blk.size() < 1) begin
            $display("FAIL %s: got %0d blocks want 1", name, cap_blk.size());
        end else begin
            b = cap_blk[0];
            if (b[511:480] !== 32'h61626380 || b[479:32] !== '0 || b[31:0] !== 32'h18
                || cap_last[0] !== 1'b1)
                $display("FAIL %s: got %h last %b want 61626380..00000018 last 1", name, b,
                         cap_last[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = 8'h00;
        i_in_last   = 1'b0;
        i_blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (o_blk_valid !== 1'b0 || o_blk_last !== 1'b0)
            $display("FAIL reset valid/last: got %b/%b want 0/0", o_blk_valid, o_blk_last);
        else n_pass++;
        n_total++;
        if (o_in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", o_in_ready);
        else n_pass++;
        n_total++;
        if (o_blk !== '0) $display("FAIL reset blk: got %h want 0", o_blk);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc();
        set_abc();
        run_msg(0, 100, "abc");
        check_abc_block("abc fields");
        n_total++;
        if (valid_first !== acc_cyc_last + 2 || valid_cnt !== 1)
            $display("FAIL abc latency: got first %0d count %0d want first %0d count 1",
                     valid_first, valid_cnt, acc_cyc_last + 2);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_blk_valid !== 1'b0) $display("FAIL abc valid drop: got %b want 0", o_blk_valid);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundaries();
        logic [511:0] b;
        m_bytes.delete();
        for (int i = 0; i < 55; i++) m_bytes.push_back(8'h00);
        run_msg(0, 100, "len55");
        n_total++;
        b = (cap_blk.size() > 0) ? cap_blk[0] : '0;
        if (b[511 - 8 * 55 -: 8] !== 8'h80 || b[63:0] !== 64'h1B8)
            $display("FAIL len55 fields: got %h want byte55 80 len 1b8", b);
        else n_pass++;

        m_bytes.delete();
        for (int i = 0; i < 56; i++) m_bytes.push_back(8'hFF);
        run_msg(0, 100, "len56");
        n_total++;
        b = (cap_blk.size() > 1) ? cap_blk[1] : '1;
        if (b[511:64] !== '0 || b[63:0] !== 64'h1C0)
            $display("FAIL len56 tail: got %h want zeros then 1c0", b);
        else n_pass++;

        m_bytes.delete();
        for (int i = 0; i < 64; i++) m_bytes.push_back(8'(i));
        run_msg(0, 100, "len64");
        n_total++;
        if (cap_blk.size() < 2 || cap_blk[0][511:480] !== 32'h00010203
            || cap_blk[1][511:480] !== 32'h80000000 || cap_blk[1][63:0] !== 64'h200)
            $display("FAIL len64 fields: got %0d blocks, want 00010203 / 80000000..200",
                     cap_blk.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bound = 0;
        set_abc();
        build_expected();
        i_blk_ready = 1'b0;
        drive_bytes(1'b1);
        @(negedge clk);
        while (!o_blk_valid && bound < 10) begin
            @(negedge clk);
            bound++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (o_blk_valid !== 1'b1 || o_in_ready !== 1'b0 || o_blk !== exp_blk[0]
                || o_blk_last !== 1'b1)
                $display("FAIL stall cyc%0d: got v%b r%b last%b blk %h want v1 r0 last1 %h",
                         i, o_blk_valid, o_in_ready, o_blk_last, o_blk, exp_blk[0]);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        i_blk_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (o_blk_valid !== 1'b1) $display("FAIL stall release: got valid %b want 1", o_blk_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (o_in_ready !== 1'b1 || o_blk_valid !== 1'b0)
            $display("FAIL after accept: got ready %b valid %b want 1 0", o_in_ready, o_blk_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        m_bytes.delete();
        for (int i = 0; i < 10; i++) m_bytes.push_back(8'($urandom));
        i_blk_ready = 1'b1;
        drive_bytes(1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (o_blk_valid !== 1'b0 || o_in_ready !== 1'b1 || o_blk !== '0)
            $display("FAIL mid reset: got valid %b ready %b blk %h want 0 1 0", o_blk_valid,
                     o_in_ready, o_blk);
        else n_pass++;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_abc();
        run_msg(0, 100, "abc after reset");
        check_abc_block("abc after reset fields");
    endtask

    task automatic test_back_to_back();
        int prev_hs;
        m_bytes.delete();
        for (int i = 0; i < 70; i++) m_bytes.push_back(8'($urandom));
        run_msg(0, 100, "b2b msg1");
        prev_hs = hs_cyc_last;
        m_bytes.delete();
        for (int i = 0; i < 20; i++) m_bytes.push_back(8'($urandom));
        run_msg(0, 100, "b2b msg2");
        n_total++;
        if (acc_cyc_first !== prev_hs + 1)
            $display("FAIL b2b first accept: got cyc %0d want %0d", acc_cyc_first, prev_hs + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int len;
        for (int m = 0; m < 12; m++) begin
            len = (m < 4) ? (119 + (m % 2) + 8 * (m / 2)) : $urandom_range(1, 200);
            m_bytes.delete();
            for (int i = 0; i < len; i++) m_bytes.push_back(8'($urandom));
            run_msg(30, 60, $sformatf("rand len%0d", len));
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
